pipe_int_ctrl: RTL and testbench

Pipeline control and interrupt-entry unit for the five-stage CPU. It drives the write-enable and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC mux select. It resolves load-use stalls, taken branches, interrupt entry and ERET. It also latches pending interrupt requests and captures SEPC from the PC field of the instruction in EX. That PC field survives a flush, so SEPC is valid even when EX holds a bubble.

---
 rtl/pipe_int_ctrl_pkg.sv | 29 ++
 rtl/pipe_int_ctrl_if.sv | 51 +++++
 rtl/pipe_int_ctrl_irq_pending.sv | 60 ++++++
 rtl/pipe_int_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_int_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_int_ctrl_pkg
// Brief    : Shared pipeline-control definitions: PC mux select encodings,
//            controller state encodings and an index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_int_ctrl_pkg;

  // PC mux select encodings
  localparam logic [1:0] PCSEL_SEQ = 2'd0;  // PC + 4
  localparam logic [1:0] PCSEL_BR  = 2'd1;  // branch target
  localparam logic [1:0] PCSEL_VEC = 2'd2;  // interrupt vector
  localparam logic [1:0] PCSEL_EPC = 2'd3;  // saved exception PC

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ISR  = 2'd1,
    ST_HOLD = 2'd2
  } ctrl_state_e;

  // Width of an index into n request lines, never less than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_int_ctrl_if
// Brief    : Hazard/interrupt inputs and pipeline control outputs of the
//            pipeline controller. The slave side is the controller itself.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_int_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  import pipe_int_ctrl_pkg::*;

  localparam int CW = idx_w(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq;
  logic               int_en;
  logic               load_use;
  logic               branch_taken;
  logic               eret_ex;
  logic [31:0]        ex_pc;

  logic               pc_we;
  logic               ifid_we;
  logic               idex_we;
  logic               exmem_we;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic [1:0]         pc_sel;
  logic [31:0]        vector_pc;
  logic [31:0]        sepc;
  logic [CW-1:0]      cause;
  logic               in_isr;
  logic [NUM_IRQ-1:0] int_ack;

  modport master (
    output irq, int_en, load_use, branch_taken, eret_ex, ex_pc,
    input  pc_we, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush,
           pc_sel, vector_pc, sepc, cause, in_isr, int_ack
  );

  modport slave (
    input  irq, int_en, load_use, branch_taken, eret_ex, ex_pc,
    output pc_we, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush,
           pc_sel, vector_pc, sepc, cause, in_isr, int_ack
  );

endinterface
`default_nettype wire

// File: rtl/pipe_int_ctrl_irq_pending.sv
`default_nettype none
// ============================================================================
// Module   : pipe_int_ctrl_irq_pending
// Brief    : Rising-edge detect on the request lines, pending register and
//            fixed-priority encoder (line 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_int_ctrl_irq_pending
  import pipe_int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic [NUM_IRQ-1:0]          irq,
  input  wire logic                        clr,       // take strobe: clear the selected line
  output logic                             any,
  output logic [idx_w(NUM_IRQ)-1:0]        sel,
  output logic [NUM_IRQ-1:0]               ack_mask
);

  localparam int CW = idx_w(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_prev_d, irq_prev_q;
  logic [NUM_IRQ-1:0] pending_d, pending_q;

  // Next pending: a new rising edge wins over a coincident clear
  always_comb begin
    irq_prev_d = irq;
    pending_d  = (pending_q & ~(clr ? ack_mask : '0)) | (irq & ~irq_prev_q);
  end

  // Pending and edge-history registers, updated with the pipeline registers
  always_ff @(negedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  // Lowest set index wins
  always_comb begin
    sel = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pending_q[k]) sel = CW'(k);
    end
  end

  // One-hot mask of the selected line, empty when nothing is pending
  always_comb begin
    any      = |pending_q;
    ack_mask = '0;
    if (any) ack_mask[sel] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_int_ctrl
// Brief    : Pipeline control and interrupt entry/exit for the five-stage
//            CPU: stall/flush/write-enable generation, PC select, SEPC and
//            cause capture. State moves on the falling edge together with
//            the pipeline registers; controls are combinational.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_int_ctrl
  import pipe_int_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
  parameter int          VEC_SHIFT = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_int_ctrl_if.slave     bus
);

  localparam int CW = idx_w(NUM_IRQ);

  ctrl_state_e         state_d, state_q;
  logic [31:0]         sepc_d, sepc_q;
  logic [CW-1:0]       cause_d, cause_q;

  logic                irq_any;
  logic [CW-1:0]       irq_sel;
  logic [NUM_IRQ-1:0]  irq_mask;
  logic                take;
  logic                exit_isr;

  pipe_int_ctrl_irq_pending #(
    .NUM_IRQ (NUM_IRQ)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .irq      (bus.irq),
    .clr      (take),
    .any      (irq_any),
    .sel      (irq_sel),
    .ack_mask (irq_mask)
  );

  assign take     = (state_q == ST_RUN) && irq_any && bus.int_en;
  assign exit_isr = (state_q == ST_ISR) && bus.eret_ex;

  // Next state plus SEPC/cause capture on a take; eret outside ISR is ignored
  always_comb begin
    state_d = state_q;
    sepc_d  = sepc_q;
    cause_d = cause_q;
    case (state_q)
      ST_RUN: begin
        if (take) begin
          state_d = ST_ISR;
          sepc_d  = bus.ex_pc;
          cause_d = irq_sel;
        end
      end
      ST_ISR:  if (bus.eret_ex) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Controller state registers
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      sepc_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      sepc_q  <= sepc_d;
      cause_q <= cause_d;
    end
  end

  // Output priority mux: take > exit > branch > load-use > sequential
  always_comb begin
    bus.pc_we       = 1'b1;
    bus.ifid_we     = 1'b1;
    bus.idex_we     = 1'b1;
    bus.exmem_we    = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.pc_sel      = PCSEL_SEQ;
    bus.int_ack     = '0;
    if (take) begin
      // The in-flight branch is squashed; it re-executes from SEPC on return
      bus.pc_sel      = PCSEL_VEC;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
      bus.int_ack     = irq_mask;
    end else if (exit_isr) begin
      bus.pc_sel     = PCSEL_EPC;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (bus.branch_taken) begin
      bus.pc_sel     = PCSEL_BR;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (bus.load_use) begin
      // Hold PC and IF/ID, insert a bubble into ID/EX
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

  assign bus.vector_pc = VEC_BASE + (32'(irq_sel) << VEC_SHIFT);
  assign bus.sepc      = sepc_q;
  assign bus.cause     = cause_q;
  assign bus.in_isr    = (state_q == ST_ISR);

endmodule
`default_nettype wire

// File: tb/tb_pipe_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_int_ctrl
// Brief    : Directed self-checking bench for pipe_int_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_int_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_int_ctrl_if #(.NUM_IRQ(4)) bus ();

  pipe_int_ctrl #(
    .NUM_IRQ   (4),
    .VEC_BASE  (32'h0000_0080),
    .VEC_SHIFT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, exmem_flush, pc_sel}
  logic [8:0] ctrl;
  assign ctrl = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we,
                 bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.pc_sel};

  localparam logic [8:0] C_IDLE = 9'b1111_000_00;
  localparam logic [8:0] C_LU   = 9'b0011_010_00;
  localparam logic [8:0] C_TAKE = 9'b1111_111_10;
  localparam logic [8:0] C_EXIT = 9'b1111_110_11;

  // Active edge is the falling edge; outputs are sampled mid-cycle
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.irq          = '0;
    bus.int_en       = 1'b0;
    bus.load_use     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.eret_ex      = 1'b0;
    bus.ex_pc        = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset then idle
    check_eq("rst_ctrl",   32'(ctrl), 32'(C_IDLE));
    check_eq("rst_sepc",   bus.sepc, 32'h0);
    check_eq("rst_in_isr", 32'(bus.in_isr), 32'h0);
    check_eq("rst_cause",  32'(bus.cause), 32'h0);
    tick();

    // Load-use stall for two cycles, bubble keeps ex_pc
    bus.load_use = 1'b1;
    bus.ex_pc    = 32'h40;
    #1;
    check_eq("lu_c0", 32'(ctrl), 32'(C_LU));
    tick();
    check_eq("lu_c1", 32'(ctrl), 32'(C_LU));
    tick();
    bus.load_use = 1'b0;
    #1;
    check_eq("lu_done", 32'(ctrl), 32'(C_IDLE));

    // Branch taken alone
    bus.branch_taken = 1'b1;
    #1;
    check_eq("br_ctrl", 32'(ctrl), 32'(9'b1111_110_01));
    tick();
    bus.branch_taken = 1'b0;

    // irq[2] rises; take occurs the following cycle
    bus.irq    = 4'b0100;
    bus.int_en = 1'b1;
    bus.ex_pc  = 32'h1C;
    #1;
    check_eq("irq2_edge_ack", 32'(bus.int_ack), 32'h0);
    tick();
    check_eq("irq2_take_ctrl", 32'(ctrl), 32'(C_TAKE));
    check_eq("irq2_vec",       bus.vector_pc, 32'hA0);
    check_eq("irq2_ack",       32'(bus.int_ack), 32'h4);
    tick();
    bus.ex_pc = 32'h24;
    #1;
    check_eq("irq2_sepc",   bus.sepc, 32'h1C);
    check_eq("irq2_cause",  32'(bus.cause), 32'h2);
    check_eq("irq2_in_isr", 32'(bus.in_isr), 32'h1);
    check_eq("isr_ctrl",    32'(ctrl), 32'(C_IDLE));

    // ERET with branch and load-use also raised: exit wins
    bus.eret_ex      = 1'b1;
    bus.branch_taken = 1'b1;
    bus.load_use     = 1'b1;
    #1;
    check_eq("eret_ctrl", 32'(ctrl), 32'(C_EXIT));
    tick();
    bus.branch_taken = 1'b0;
    bus.load_use     = 1'b0;
    // HOLD: eret outside ISR is ignored
    #1;
    check_eq("hold_in_isr", 32'(bus.in_isr), 32'h0);
    check_eq("hold_eret",   32'(ctrl), 32'(C_IDLE));
    tick();
    // RUN: eret ignored, no state change
    #1;
    check_eq("run_eret", 32'(ctrl), 32'(C_IDLE));
    tick();
    bus.eret_ex = 1'b0;
    #1;
    check_eq("run_eret_state", 32'(bus.in_isr), 32'h0);

    // irq[3] and irq[1] together: line 1 first, line 3 after ERET + HOLD
    bus.irq   = 4'b1010;
    bus.ex_pc = 32'h50;
    tick();
    check_eq("dual_take_ack", 32'(bus.int_ack), 32'h2);
    check_eq("dual_take_vec", bus.vector_pc, 32'h90);
    check_eq("dual_take_sel", 32'(bus.pc_sel), 32'h2);
    tick();
    bus.irq = 4'b0000;
    #1;
    check_eq("dual_cause1",   32'(bus.cause), 32'h1);
    check_eq("dual_sepc",     bus.sepc, 32'h50);
    check_eq("no_nest_ack",   32'(bus.int_ack), 32'h0);
    check_eq("no_nest_ctrl",  32'(ctrl), 32'(C_IDLE));
    tick();
    bus.eret_ex = 1'b1;
    #1;
    check_eq("dual_eret", 32'(bus.pc_sel), 32'h3);
    tick();
    bus.eret_ex = 1'b0;
    #1;
    check_eq("hold_no_take_ack",  32'(bus.int_ack), 32'h0);
    check_eq("hold_no_take_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    check_eq("line3_ack", 32'(bus.int_ack), 32'h8);
    check_eq("line3_vec", bus.vector_pc, 32'hB0);
    check_eq("line3_sel", 32'(bus.pc_sel), 32'h2);
    tick();
    check_eq("line3_cause", 32'(bus.cause), 32'h3);
    bus.eret_ex = 1'b1;
    tick();
    bus.eret_ex = 1'b0;
    tick();

    // int_en low: pending retained, taken once enabled
    bus.int_en = 1'b0;
    bus.irq    = 4'b0001;
    tick();
    check_eq("dis_no_take", 32'(bus.int_ack), 32'h0);
    tick();
    check_eq("dis_still_idle", 32'(ctrl), 32'(C_IDLE));
    bus.int_en       = 1'b1;
    bus.branch_taken = 1'b1;
    bus.ex_pc        = 32'h30;
    bus.irq          = 4'b0101;  // irq[2] edge lands on the take edge
    #1;
    check_eq("br_take_ack", 32'(bus.int_ack), 32'h1);
    check_eq("br_take_vec", bus.vector_pc, 32'h80);
    check_eq("br_take_sel", 32'(bus.pc_sel), 32'h2);
    tick();
    bus.branch_taken = 1'b0;
    #1;
    check_eq("br_take_sepc",   bus.sepc, 32'h30);
    check_eq("br_take_in_isr", 32'(bus.in_isr), 32'h1);

    // Reset in the ISR cycle clears state, SEPC and pending
    rst     = 1'b1;
    bus.irq = 4'b0000;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_in_isr", 32'(bus.in_isr), 32'h0);
    check_eq("mid_rst_sepc",   bus.sepc, 32'h0);
    check_eq("mid_rst_cause",  32'(bus.cause), 32'h0);
    check_eq("mid_rst_ack",    32'(bus.int_ack), 32'h0);
    tick();
    check_eq("mid_rst_pend_ack",  32'(bus.int_ack), 32'h0);
    check_eq("mid_rst_pend_ctrl", 32'(ctrl), 32'(C_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
